// File: rtl/pisirme_kontrol_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pisirme_kontrol_pkg
//  Purpose  : Shared state encodings, reject codes and valve helper for the
//             cooking-sequence controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pisirme_kontrol_pkg;

   // Controller states, 3-bit binary
   typedef enum logic [2:0] {
      BEKLE = 3'd0,
      DOZAJ = 3'd1,
      PISIR = 3'd2,
      HAZIR = 3'd3,
      RED   = 3'd4
   } durum_t;

   // Reject reason codes
   localparam logic [1:0] RED_YOK   = 2'b00;
   localparam logic [1:0] RED_TUZLU = 2'b01;
   localparam logic [1:0] RED_BOS   = 2'b10;

   // One-hot valve drive for the selected ingredient
   function automatic logic [1:0] vana_kodla(input logic sec);
      return sec ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pisirme_kontrol_kenar_algilayici.sv
`default_nettype none
// ============================================================================
//  Module   : kenar_algilayici
//  Purpose  : Rising-edge detector. The pulse is combinational against the
//             registered history, so the consumer samples it on the same edge
//             the history flop updates.
//  Revision : 1.0 - initial release
// ============================================================================
module kenar_algilayici (
   input  logic saat,
   input  logic reset,
   input  logic giris,
   output logic kenar
);

   logic onceki_d;
   logic onceki_q;

   // History follows the input every cycle
   always_comb begin
      onceki_d = giris;
   end

   // History flop, cleared to 0 so a level held through reset yields one edge
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) onceki_q <= 1'b0;
      else        onceki_q <= onceki_d;
   end

   assign kenar = giris & ~onceki_q;

endmodule
`default_nettype wire

// File: rtl/pisirme_kontrol.sv
`default_nettype none
// ============================================================================
//  Module   : pisirme_kontrol
//  Purpose  : Cooking sequencer. Latches an order on the rising edge of the
//             upstream done flag, dispenses timed portions, runs the cook
//             timer and holds the dish until served. Salty/empty orders are
//             rejected with a one-cycle pulse and reason code.
//  Revision : 1.0 - initial release
// ============================================================================
module pisirme_kontrol
   import pisirme_kontrol_pkg::*;
#(
   parameter int unsigned PORSIYON_SURESI = 4,
   parameter int unsigned PISIRME_SURESI  = 8,
   parameter int unsigned SAYAC_GENISLIGI = 8
) (
   input  logic       saat,
   input  logic       reset,
   input  logic       bitti,
   input  logic       secilen_malzeme,
   input  logic [3:0] malzeme_miktari,
   input  logic       cikis_tuzlu,
   input  logic       servis,
   output logic       mesgul,
   output logic [1:0] vana,
   output logic [3:0] porsiyon_sayisi,
   output logic       hazir,
   output logic       reddedildi,
   output logic [1:0] red_kodu
);

   localparam logic [SAYAC_GENISLIGI-1:0] PORSIYON_SON = SAYAC_GENISLIGI'(PORSIYON_SURESI - 1);
   localparam logic [SAYAC_GENISLIGI-1:0] PISIRME_SON  = SAYAC_GENISLIGI'(PISIRME_SURESI - 1);
   localparam logic [SAYAC_GENISLIGI-1:0] SAYAC_BIR    = SAYAC_GENISLIGI'(1);

   logic basla;

   durum_t                     durum_d,    durum_q;
   logic                       sec_d,      sec_q;
   logic [3:0]                 miktar_d,   miktar_q;
   logic [1:0]                 kod_d,      kod_q;
   logic [SAYAC_GENISLIGI-1:0] sayac_d,    sayac_q;
   logic [3:0]                 porsiyon_d, porsiyon_q;
   logic                       mesgul_d,   mesgul_q;
   logic [1:0]                 vana_d,     vana_q;
   logic                       hazir_d,    hazir_q;
   logic                       red_d,      red_q;
   logic [1:0]                 red_kodu_d, red_kodu_q;
   logic [3:0]                 porsiyon_artti;

   kenar_algilayici u_bitti_kenar (
      .saat  (saat),
      .reset (reset),
      .giris (bitti),
      .kenar (basla)
   );

   assign porsiyon_artti = porsiyon_q + 4'd1;

   // Next-state, order latch, counters, and outputs decoded from the next state
   always_comb begin
      durum_d    = durum_q;
      sec_d      = sec_q;
      miktar_d   = miktar_q;
      kod_d      = kod_q;
      sayac_d    = sayac_q;
      porsiyon_d = porsiyon_q;

      case (durum_q)
         BEKLE: begin
            if (basla) begin
               sec_d      = secilen_malzeme;
               miktar_d   = malzeme_miktari;
               sayac_d    = '0;
               porsiyon_d = 4'd0;
               if (cikis_tuzlu) begin
                  durum_d = RED;
                  kod_d   = RED_TUZLU;
               end else if (malzeme_miktari == 4'd0) begin
                  durum_d = RED;
                  kod_d   = RED_BOS;
               end else begin
                  durum_d = DOZAJ;
                  kod_d   = RED_YOK;
               end
            end
         end
         DOZAJ: begin
            if (sayac_q == PORSIYON_SON) begin
               sayac_d    = '0;
               porsiyon_d = porsiyon_artti;
               // Last portion done: cook counter starts from zero
               if (porsiyon_artti == miktar_q) durum_d = PISIR;
            end else begin
               sayac_d = sayac_q + SAYAC_BIR;
            end
         end
         PISIR: begin
            if (sayac_q == PISIRME_SON) begin
               sayac_d = '0;
               durum_d = HAZIR;
            end else begin
               sayac_d = sayac_q + SAYAC_BIR;
            end
         end
         HAZIR: begin
            if (servis) begin
               durum_d    = BEKLE;
               porsiyon_d = 4'd0;
            end
         end
         RED: begin
            durum_d = BEKLE;
            kod_d   = RED_YOK;
         end
         default: durum_d = BEKLE;
      endcase

      mesgul_d   = (durum_d != BEKLE);
      vana_d     = (durum_d == DOZAJ) ? vana_kodla(sec_d) : 2'b00;
      hazir_d    = (durum_d == HAZIR);
      red_d      = (durum_d == RED);
      red_kodu_d = (durum_d == RED) ? kod_d : RED_YOK;
   end

   // State, latched order, counters and registered Moore outputs
   always_ff @(posedge saat or negedge reset) begin
      if (!reset) begin
         durum_q    <= BEKLE;
         sec_q      <= 1'b0;
         miktar_q   <= 4'd0;
         kod_q      <= RED_YOK;
         sayac_q    <= '0;
         porsiyon_q <= 4'd0;
         mesgul_q   <= 1'b0;
         vana_q     <= 2'b00;
         hazir_q    <= 1'b0;
         red_q      <= 1'b0;
         red_kodu_q <= RED_YOK;
      end else begin
         durum_q    <= durum_d;
         sec_q      <= sec_d;
         miktar_q   <= miktar_d;
         kod_q      <= kod_d;
         sayac_q    <= sayac_d;
         porsiyon_q <= porsiyon_d;
         mesgul_q   <= mesgul_d;
         vana_q     <= vana_d;
         hazir_q    <= hazir_d;
         red_q      <= red_d;
         red_kodu_q <= red_kodu_d;
      end
   end

   assign mesgul          = mesgul_q;
   assign vana            = vana_q;
   assign porsiyon_sayisi = porsiyon_q;
   assign hazir           = hazir_q;
   assign reddedildi      = red_q;
   assign red_kodu        = red_kodu_q;

endmodule
`default_nettype wire
